// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle Hack function mode plus iterative SLL/SRA and shift-add MUL.
// Optional macro ALU_MUL_EN builds the multiplier; without it mode 11 reports illegal.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_HACK = 2'b00;
  localparam logic [1:0] M_SLL  = 2'b01;
  localparam logic [1:0] M_SRA  = 2'b10;
  localparam logic [1:0] M_MUL  = 2'b11;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             illegal_q;

  logic [SHW-1:0]   s_amt;
  logic [WIDTH:0]   hack_d;
  logic [WIDTH:0]   sh_acc_d;
  logic [WIDTH:0]   sh_run_d;

  // Returns {carry, result} of the Hack function on a and b.
  function automatic logic [WIDTH:0] hack_op(input logic [5:0] f,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] a1, b1, r;
    logic [WIDTH:0]   s;
    a1 = f[5] ? '0 : a;
    a1 = f[4] ? ~a1 : a1;
    b1 = f[3] ? '0 : b;
    b1 = f[2] ? ~b1 : b1;
    s  = {1'b0, a1} + {1'b0, b1};
    r  = f[1] ? s[WIDTH-1:0] : (a1 & b1);
    r  = f[0] ? ~r : r;
    return {f[1] & s[WIDTH], r};
  endfunction

  // One-bit shift; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic sra,
                                                input logic [WIDTH-1:0] v);
    if (sra) return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
    else     return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
  endfunction

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [2*WIDTH-1:0] mul_run_d;

  // One shift-add step on the {hi, lo} product register; lo starts as the multiplier.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] mc);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    return {sum, lo[WIDTH-1:1]};
  endfunction
`endif

  always_comb begin
    s_amt    = y[SHW-1:0];
    hack_d   = hack_op(fn, x, y);
    sh_acc_d = shift_step(mode[1], x);
    sh_run_d = shift_step(mode_q[1], out_q);
`ifdef ALU_MUL_EN
    mul_acc_d = mul_step('0, y, x);
    mul_run_d = mul_step(hi_q, out_q, mcand_q);
`endif
  end

  // The accept edge performs the first iteration so results land at cycle max(n,1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= M_HACK;
      cnt_q     <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q      <= '0;
      mcand_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q    <= mode;
            illegal_q <= 1'b0;
            case (mode)
              M_HACK: begin
                out_q   <= hack_d[WIDTH-1:0];
                carry_q <= hack_d[WIDTH];
                state_q <= DONE;
              end
              M_SLL, M_SRA: begin
                if (s_amt == '0) begin
                  out_q   <= x;
                  carry_q <= 1'b0;
                  state_q <= DONE;
                end else begin
                  out_q   <= sh_acc_d[WIDTH-1:0];
                  carry_q <= sh_acc_d[WIDTH];
                  cnt_q   <= s_amt - 1'b1;
                  state_q <= (s_amt == SHW'(1)) ? DONE : RUN;
                end
              end
              default: begin
`ifdef ALU_MUL_EN
                {hi_q, out_q} <= mul_acc_d;
                mcand_q       <= x;
                carry_q       <= 1'b0;
                cnt_q         <= SHW'(WIDTH - 1);
                state_q       <= RUN;
`else
                out_q     <= '0;
                carry_q   <= 1'b0;
                illegal_q <= 1'b1;
                state_q   <= DONE;
`endif
              end
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) state_q <= DONE;
          if (mode_q == M_MUL) begin
`ifdef ALU_MUL_EN
            {hi_q, out_q} <= mul_run_d;
            if (cnt_q == SHW'(1)) carry_q <= |mul_run_d[2*WIDTH-1:WIDTH];
`endif
          end else begin
            out_q   <= sh_run_d[WIDTH-1:0];
            carry_q <= sh_run_d[WIDTH];
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign zero      = (out_q == '0);
  assign neg       = out_q[WIDTH-1];
  assign carry     = carry_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=16): driver pushes reference results, monitor pops on out_valid.
// Honours ALU_MUL_EN in the reference model to match the build of the design.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [5:0]   fn;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         illegal;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .fn(fn), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .neg(neg), .carry(carry), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    logic         illegal;
    int           lat;
    time          t0;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   hold_req  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Reference model straight from the operation definitions.
  function automatic exp_t model(input logic [1:0] m, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] xa, yb, r;
    int unsigned  sum, s;
    logic [31:0]  wide;
    e.carry = 1'b0; e.illegal = 1'b0; e.lat = 1; e.t0 = 0;
    s = int'(b[3:0]);
    case (m)
      2'b00: begin
        xa = f[5] ? 16'd0 : a;  if (f[4]) xa = ~xa;
        yb = f[3] ? 16'd0 : b;  if (f[2]) yb = ~yb;
        sum = int'(xa) + int'(yb);
        r = f[1] ? sum[15:0] : (xa & yb);
        e.out   = f[0] ? ~r : r;
        e.carry = f[1] && (sum >= 32'd65536);
      end
      2'b01: begin
        wide    = {16'd0, a} << s;
        e.out   = wide[15:0];
        e.carry = (s != 0) && wide[16];
        e.lat   = (s == 0) ? 1 : int'(s);
      end
      2'b10: begin
        e.out   = W'($signed(a) >>> s);
        e.carry = (s != 0) && a[s-1];
        e.lat   = (s == 0) ? 1 : int'(s);
      end
      default: begin
`ifdef ALU_MUL_EN
        wide    = int'(a) * int'(b);
        e.out   = wide[15:0];
        e.carry = (wide[31:16] != 0);
        e.lat   = W;
`else
        e.out     = '0;
        e.illegal = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] m, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    bit   ok = 0;
    @(negedge clk);
    mode = m; fn = f; x = a; y = b; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else if (push) begin
      e = model(m, f, a, b);
      e.t0 = $time;
      q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    mode = 2'($urandom); fn = 6'($urandom); x = W'($urandom); y = W'($urandom);
  endtask

  // Monitor: compare on out_valid, apply random backpressure, verify release to IDLE.
  initial begin
    exp_t         e;
    int           hold;
    logic [W-1:0] so;
    logic [3:0]   sf;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out", out, e.out);
          chk("zero", zero, (e.out == 0));
          chk("neg", neg, e.out[W-1]);
          chk("carry", carry, e.carry);
          chk("illegal", illegal, e.illegal);
          chk("latency", int'(($time - e.t0 - 5) / 10) + 1, e.lat);
          chk("in_ready_busy", in_ready, 0);
        end
        hold = (hold_req >= 0) ? hold_req : int'($urandom_range(0, 3));
        hold_req = -1;
        so = out; sf = {zero, neg, carry, illegal};
        repeat (hold) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_out", out, so);
          chk("hold_flags", {zero, neg, carry, illegal}, sf);
          chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_idle", {out_valid, in_ready}, 2'b01);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] edges[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; mode = '0; fn = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {in_ready, out_valid}, 2'b10);
    chk("rst_out", out, 0);
    chk("rst_flags", {zero, neg, carry, illegal}, 4'b1000);
    rst = 1'b0;

    issue(2'b00, 6'b000010, 16'h7FFF, 16'h0001, 1);
    issue(2'b00, 6'b000010, 16'hFFFF, 16'h0001, 1);
    issue(2'b00, 6'b101010, 16'h1234, 16'h5678, 1);
    issue(2'b01, 6'b000000, 16'h0001, 16'd4, 1);
    issue(2'b10, 6'b000000, 16'h8000, 16'd15, 1);
    issue(2'b10, 6'b000000, 16'hA5C3, 16'd0, 1);
    issue(2'b11, 6'b000000, 16'd300, 16'd300, 1);
    hold_req = 3;
    issue(2'b00, 6'b000111, 16'h00F0, 16'h000F, 1);

    // Abort an operation in flight: rst sampled at the edge of cycle 5.
`ifdef ALU_MUL_EN
    issue(2'b11, 6'b000000, 16'd1234, 16'd4321, 0);
`else
    issue(2'b01, 6'b000000, 16'h0003, 16'd12, 0);
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", {in_ready, out_valid}, 2'b10);
    chk("abort_out", out, 0);
    chk("abort_zero", zero, 1);
    rst = 1'b0;
    issue(2'b00, 6'b000010, 16'h1111, 16'h2222, 1);

    for (int i = 0; i < 250; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      issue(2'($urandom), 6'($urandom), ra, rb, 1);
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
